// File: rtl/stream_pack.sv
// Narrow-to-wide stream packer: gathers RATIO beats of IN_WIDTH bits into one
// registered output word, flushing early on w_last.

module stream_pack_lane #(
  parameter int W   = 8,
  parameter int IDX = 0,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          clr,
  input  logic [CW-1:0] cnt,
  input  logic [W-1:0]  w_data,
  output logic [W-1:0]  ld_data,
  output logic          ld_keep
);
  logic [W-1:0] acc;
  logic         acc_keep;
  logic         sel;

  assign sel = (cnt == CW'(IDX));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      acc_keep <= 1'b0;
    end else if (clr) begin
      acc_keep <= 1'b0;
    end else if (wr && sel) begin
      acc      <= w_data;
      acc_keep <= 1'b1;
    end
  end

  // Lanes already filled this packet come from the accumulator, the current
  // lane takes the incoming beat, lanes beyond it are zero.
  assign ld_keep = acc_keep | sel;
  assign ld_data = acc_keep ? acc : (sel ? w_data : '0);
endmodule

module stream_pack #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [IN_WIDTH-1:0]       w_data,
  input  logic                      w_last,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [IN_WIDTH*RATIO-1:0] r_data,
  output logic [RATIO-1:0]          r_keep,
  output logic                      r_last
);
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (RATIO < 1 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
      $fatal(1, "stream_pack: RATIO must be a power of 2 and >= 1");
    end
  endgenerate

  logic [CW-1:0]                  cnt;
  logic                           take, complete, vld_q;
  logic [RATIO-1:0][IN_WIDTH-1:0] ld_data;
  logic [RATIO-1:0]               ld_keep;

  // Gating with rst keeps a pending word from transferring during reset.
  assign r_valid  = vld_q & ~rst;
  assign w_ready  = ~r_valid | r_ready;
  assign take     = w_valid & w_ready;
  assign complete = take & (w_last | (cnt == CW'(RATIO - 1)));

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    stream_pack_lane #(.W(IN_WIDTH), .IDX(i), .CW(CW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr      (take & ~complete),
      .clr     (complete),
      .cnt     (cnt),
      .w_data  (w_data),
      .ld_data (ld_data[i]),
      .ld_keep (ld_keep[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)           cnt <= '0;
    else if (complete) cnt <= '0;
    else if (take)     cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
    end else if (complete) begin
      vld_q  <= 1'b1;
      r_data <= ld_data;
      r_keep <= ld_keep;
      r_last <= w_last;
    end else if (vld_q && r_ready) begin
      vld_q  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_pack.sv
// Bench for stream_pack: directed steps plus random traffic on a RATIO=4 and a
// RATIO=1 instance, both scored against a queue-based packet model.

module tb_stream_pack;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        w_valid, w_ready, w_last, r_valid, r_ready, r_last;
  logic [7:0]  w_data;
  logic [31:0] r_data;
  logic [3:0]  r_keep;

  logic        w_valid1, w_ready1, w_last1, r_valid1, r_ready1, r_last1;
  logic [7:0]  w_data1, r_data1;
  logic [0:0]  r_keep1;

  int passed = 0;
  int total  = 0;

  stream_pack #(.IN_WIDTH(8), .RATIO(4)) u_dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_last(w_last), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_keep(r_keep), .r_last(r_last));

  stream_pack #(.IN_WIDTH(8), .RATIO(1)) u_dut1 (
    .clk(clk), .rst(rst), .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1),
    .w_last(w_last1), .r_valid(r_valid1), .r_ready(r_ready1), .r_data(r_data1),
    .r_keep(r_keep1), .r_last(r_last1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Model: beats gather until RATIO of them or a last beat, then become one
  // expected word that must be the next one drained.
  logic [7:0] acc0[$];
  word_t      exp0[$], exp1[$];

  always @(negedge clk) begin : mon0
    word_t e, n;
    if (rst) begin
      acc0.delete();
      exp0.delete();
    end else begin
      check("w_ready_rule", w_ready, !r_valid || r_ready);
      check("r_valid_outstanding", r_valid, exp0.size() != 0);
      if (r_valid && r_ready && exp0.size() != 0) begin
        e = exp0.pop_front();
        check("word_data", r_data, e.d);
        check("word_keep", r_keep, e.k);
        check("word_last", r_last, e.l);
      end
      if (w_valid && w_ready) begin
        acc0.push_back(w_data);
        if (acc0.size() == 4 || w_last) begin
          n.d = '0;
          foreach (acc0[i]) n.d |= {24'b0, acc0[i]} << (8 * i);
          n.k = 4'((1 << acc0.size()) - 1);
          n.l = w_last;
          exp0.push_back(n);
          acc0.delete();
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    word_t e, n;
    if (rst) begin
      exp1.delete();
    end else begin
      check("r1_w_ready_rule", w_ready1, !r_valid1 || r_ready1);
      check("r1_r_valid_outstanding", r_valid1, exp1.size() != 0);
      if (r_valid1 && r_ready1 && exp1.size() != 0) begin
        e = exp1.pop_front();
        check("r1_word_data", r_data1, e.d[7:0]);
        check("r1_word_keep", r_keep1, 1'b1);
        check("r1_word_last", r_last1, e.l);
      end
      if (w_valid1 && w_ready1) begin
        n.d = {24'b0, w_data1};
        n.k = 4'b0001;
        n.l = w_last1;
        exp1.push_back(n);
      end
    end
  end

  task automatic send(input bit sel, input logic [7:0] d, input bit l, output int waits);
    waits = 0;
    if (sel) begin w_valid1 = 1'b1; w_data1 = d; w_last1 = l; end
    else     begin w_valid  = 1'b1; w_data  = d; w_last  = l; end
    @(negedge clk);
    while (!(sel ? w_ready1 : w_ready) && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("send_accept_timeout", waits < 50, 1'b1);
    @(posedge clk); #1;
    if (sel) w_valid1 = 1'b0;
    else     w_valid  = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  initial begin
    int wt;
    rst = 1'b1;
    w_valid = 0; w_data = 0; w_last = 0; r_ready = 1;
    w_valid1 = 0; w_data1 = 0; w_last1 = 0; r_ready1 = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_r_data", r_data, 32'h0);
    check("rst_r_keep", r_keep, 4'h0);
    check("rst_r_last", r_last, 1'b0);
    check("rst_w_ready", w_ready, 1'b1);
    check("rst_r1_valid", r_valid1, 1'b0);
    gap();

    // Full word
    send(0, 8'h11, 0, wt); send(0, 8'h22, 0, wt);
    send(0, 8'h33, 0, wt); send(0, 8'h44, 0, wt);
    @(negedge clk);
    check("t1_valid", r_valid, 1'b1);
    check("t1_data", r_data, 32'h44332211);
    check("t1_keep", r_keep, 4'b1111);
    check("t1_last", r_last, 1'b0);
    gap();

    // Short packet
    send(0, 8'hAA, 0, wt); send(0, 8'hBB, 1, wt);
    @(negedge clk);
    check("t2_valid", r_valid, 1'b1);
    check("t2_data", r_data, 32'h0000BBAA);
    check("t2_keep", r_keep, 4'b0011);
    check("t2_last", r_last, 1'b1);
    gap();

    // Streaming at full rate
    for (int i = 1; i <= 12; i++) begin
      send(0, 8'(i), 0, wt);
      check("t3_no_wait", wt, 0);
    end
    repeat (2) gap();

    // Backpressure
    r_ready = 1'b0;
    send(0, 8'hA1, 0, wt); send(0, 8'hA2, 0, wt);
    send(0, 8'hA3, 0, wt); send(0, 8'hA4, 0, wt);
    w_valid = 1'b1; w_data = 8'hB5; w_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_w_ready_low", w_ready, 1'b0);
      check("t4_valid", r_valid, 1'b1);
      check("t4_data_stable", r_data, 32'hA4A3A2A1);
      check("t4_keep_stable", r_keep, 4'b1111);
      check("t4_last_stable", r_last, 1'b0);
    end
    gap();
    r_ready = 1'b1;
    @(negedge clk);
    check("t4_w_ready_high", w_ready, 1'b1);
    gap();
    w_valid = 1'b0;
    send(0, 8'hB6, 1, wt);
    @(negedge clk);
    check("t4_next_data", r_data, 32'h0000B6B5);
    check("t4_next_keep", r_keep, 4'b0011);
    gap();

    // Reset mid-packet
    send(0, 8'h55, 0, wt); send(0, 8'h66, 0, wt);
    rst = 1'b1;
    gap();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, 8'(i), 0, wt);
    @(negedge clk);
    check("t5_data", r_data, 32'h04030201);
    check("t5_keep", r_keep, 4'b1111);
    gap();

    // RATIO=1 instance
    send(1, 8'h7E, 1, wt);
    @(negedge clk);
    check("t6_valid_a", r_valid1, 1'b1);
    check("t6_data_a", r_data1, 8'h7E);
    check("t6_keep_a", r_keep1, 1'b1);
    check("t6_last_a", r_last1, 1'b1);
    send(1, 8'h7F, 0, wt);
    @(negedge clk);
    check("t6_valid_b", r_valid1, 1'b1);
    check("t6_data_b", r_data1, 8'h7F);
    check("t6_last_b", r_last1, 1'b0);
    gap();

    // Random traffic on both instances
    for (int c = 0; c < 400; c++) begin
      w_valid  = $urandom_range(0, 3) != 0;
      w_data   = 8'($urandom);
      w_last   = $urandom_range(0, 3) == 0;
      r_ready  = $urandom_range(0, 3) != 0;
      w_valid1 = $urandom_range(0, 1) != 0;
      w_data1  = 8'($urandom);
      w_last1  = $urandom_range(0, 1) != 0;
      r_ready1 = $urandom_range(0, 2) != 0;
      gap();
    end
    w_valid = 0; w_valid1 = 0; r_ready = 1; r_ready1 = 1;
    repeat (4) gap();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
